// File: rtl/issue_operand_fetch.sv
// issue_operand_fetch: 3-wide operand-fetch stage between issue and execute.
//
// Each lane's two source registers go out as register-file read indices.
// The operands that come back are patched with same-cycle CDB results.
// This patch is needed because the register file only commits CDB writes at
// the next edge.
//
// Fetched bundles land in a 2-entry circular buffer. Because of this buffer,
// issue_ready depends only on registered occupancy and never on ex_ready.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   squash              pipeline flush: empties the buffer at the next edge
//   issue_valid/src1/src2/payload   upstream bundle (WAYS lanes)
//   issue_ready         buffer can take one bundle this cycle
//   rf_read_idx_1/2     register file read indices (mirror of issue_src1/2)
//   rf_read_out_1/2     register file read data, same cycle
//   cdb_tag, cdb_data   this cycle's three CDB writes (ZERO_PR tag = none)
//   ex_valid/src1_val/src2_val/payload   head bundle toward execute
//   ex_ready            execute consumes the head bundle this cycle

package issue_operand_fetch_pkg;
    typedef struct packed {
        logic [5:0] t0;
        logic [5:0] t1;
        logic [5:0] t2;
    } CDB_T_PACKET;
endpackage

module issue_operand_fetch
    import issue_operand_fetch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PR        = 6,
    parameter int WAYS      = 3,
    parameter int PAYLOAD_W = 64,
    parameter logic [PR-1:0] ZERO_PR = {PR{1'b0}}
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              squash,
    input  logic [WAYS-1:0]                   issue_valid,
    input  logic [WAYS-1:0][PR-1:0]           issue_src1,
    input  logic [WAYS-1:0][PR-1:0]           issue_src2,
    input  logic [WAYS-1:0][PAYLOAD_W-1:0]    issue_payload,
    output logic                              issue_ready,
    output logic [WAYS-1:0][PR-1:0]           rf_read_idx_1,
    output logic [WAYS-1:0][PR-1:0]           rf_read_idx_2,
    input  logic [WAYS-1:0][XLEN-1:0]         rf_read_out_1,
    input  logic [WAYS-1:0][XLEN-1:0]         rf_read_out_2,
    input  CDB_T_PACKET                       cdb_tag,
    input  logic [2:0][XLEN-1:0]              cdb_data,
    output logic [WAYS-1:0]                   ex_valid,
    output logic [WAYS-1:0][XLEN-1:0]         ex_src1_val,
    output logic [WAYS-1:0][XLEN-1:0]         ex_src2_val,
    output logic [WAYS-1:0][PAYLOAD_W-1:0]    ex_payload,
    input  logic                              ex_ready
);

    // Operand priority: hard-wired zero register, then CDB (lowest slot
    // first), then the register file.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [PR-1:0]         src,
        input logic [2:0][PR-1:0]    tags,
        input logic [2:0][XLEN-1:0]  data,
        input logic [XLEN-1:0]       rf_val
    );
        logic [XLEN-1:0] result;
        if (src == ZERO_PR) begin
            result = {XLEN{1'b0}};
        end else if ((tags[0] != ZERO_PR) && (tags[0] == src)) begin
            result = data[0];
        end else if ((tags[1] != ZERO_PR) && (tags[1] == src)) begin
            result = data[1];
        end else if ((tags[2] != ZERO_PR) && (tags[2] == src)) begin
            result = data[2];
        end else begin
            result = rf_val;
        end
        return result;
    endfunction

    logic [2:0][PR-1:0]                    cdb_tags_s;
    logic [WAYS-1:0][XLEN-1:0]             fetch_src1_s;
    logic [WAYS-1:0][XLEN-1:0]             fetch_src2_s;
    logic                                  issue_fire_s;
    logic                                  ex_fire_s;
    logic [1:0]                            count_next_s;

    logic [1:0][WAYS-1:0]                  buf_valid_r;
    logic [1:0][WAYS-1:0][XLEN-1:0]        buf_src1_r;
    logic [1:0][WAYS-1:0][XLEN-1:0]        buf_src2_r;
    logic [1:0][WAYS-1:0][PAYLOAD_W-1:0]   buf_payload_r;
    logic                                  head_r;
    logic                                  tail_r;
    logic [1:0]                            count_r;

    assign cdb_tags_s    = {PR'(cdb_tag.t2), PR'(cdb_tag.t1), PR'(cdb_tag.t0)};
    assign rf_read_idx_1 = issue_src1;
    assign rf_read_idx_2 = issue_src2;

    // Ready is decoded from occupancy only, so a full buffer stalls issue
    // even when execute drains the head in the same cycle.
    assign issue_ready  = (count_r != 2'd2);
    assign issue_fire_s = issue_ready & (|issue_valid) & ~squash;
    assign ex_fire_s    = (count_r != 2'd0) & ex_ready;

    // Per-lane operand selection with CDB forwarding.
    always_comb begin
        fetch_src1_s = {(WAYS*XLEN){1'b0}};
        fetch_src2_s = {(WAYS*XLEN){1'b0}};
        for (int l = 0; l < WAYS; l++) begin
            fetch_src1_s[l] = select_operand(issue_src1[l], cdb_tags_s, cdb_data, rf_read_out_1[l]);
            fetch_src2_s[l] = select_operand(issue_src2[l], cdb_tags_s, cdb_data, rf_read_out_2[l]);
        end
    end

    // Occupancy update; simultaneous enqueue and dequeue leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({issue_fire_s, ex_fire_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Head entry drives execute; lane valids are masked when the buffer is empty.
    always_comb begin
        ex_src1_val = buf_src1_r[head_r];
        ex_src2_val = buf_src2_r[head_r];
        ex_payload  = buf_payload_r[head_r];
        if (count_r != 2'd0) begin
            ex_valid = buf_valid_r[head_r];
        end else begin
            ex_valid = {WAYS{1'b0}};
        end
    end

    // Buffer storage and pointers. Squash only rewinds the control state.
    // Stale entry contents are never exposed, because ex_valid is masked by count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_r   <= {(2*WAYS){1'b0}};
            buf_src1_r    <= {(2*WAYS*XLEN){1'b0}};
            buf_src2_r    <= {(2*WAYS*XLEN){1'b0}};
            buf_payload_r <= {(2*WAYS*PAYLOAD_W){1'b0}};
            head_r        <= 1'b0;
            tail_r        <= 1'b0;
            count_r       <= 2'd0;
        end else if (squash) begin
            head_r        <= 1'b0;
            tail_r        <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (issue_fire_s) begin
                buf_valid_r[tail_r]   <= issue_valid;
                buf_src1_r[tail_r]    <= fetch_src1_s;
                buf_src2_r[tail_r]    <= fetch_src2_s;
                buf_payload_r[tail_r] <= issue_payload;
                tail_r                <= ~tail_r;
            end
            if (ex_fire_s) begin
                head_r <= ~head_r;
            end
            count_r <= count_next_s;
        end
    end

endmodule
